// File: rtl/interpolator.sv
// interpolator: AXI-Stream upsampler that re-emits each accepted sample RATIO times (hold or zero-stuff).
module interpolator #(
  parameter int RATIO      = 5,
  parameter bit ZERO_STUFF = 1'b0
) (
  input  logic        s_axis_aclk,
  input  logic        s_axis_areset,
  input  logic [23:0] s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic [2:0]  s_axis_tuser,
  input  logic        s_axis_tlast,
  output logic [23:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [2:0]  m_axis_tuser,
  output logic        m_axis_tlast
);
  localparam int CW = RATIO > 1 ? $clog2(RATIO) : 1;
  logic [23:0]   hold_data;
  logic [2:0]    hold_user;
  logic          hold_last;
  logic          busy;
  logic [CW-1:0] rep_cnt;
  logic          last_rep;
  logic          s_fire;
  logic          m_fire;
  assign last_rep      = rep_cnt == CW'(RATIO - 1);
  assign s_axis_tready = !busy || (m_axis_tready && last_rep);
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign m_fire        = busy && m_axis_tready;
  assign m_axis_tvalid = busy;
  assign m_axis_tuser  = hold_user;
  assign m_axis_tdata  = (!ZERO_STUFF || rep_cnt == '0) ? hold_data : 24'd0;
  assign m_axis_tlast  = hold_last && last_rep;
  // A new beat can only be accepted when idle or on the final replica, so loading always restarts the count.
  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      hold_data <= '0;
      hold_user <= '0;
      hold_last <= 1'b0;
      busy      <= 1'b0;
      rep_cnt   <= '0;
    end else if (s_fire) begin
      hold_data <= s_axis_tdata;
      hold_user <= s_axis_tuser;
      hold_last <= s_axis_tlast;
      busy      <= 1'b1;
      rep_cnt   <= '0;
    end else if (m_fire) begin
      rep_cnt <= last_rep ? '0 : rep_cnt + 1'b1;
      busy    <= !last_rep;
    end
  end
endmodule

// File: tb/tb_interpolator.sv
// tb_interpolator: scoreboard bench over hold (RATIO=5), zero-stuff (RATIO=5) and RATIO=1 instances.
module tb_interpolator;
  localparam int N = 3;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] s_data[N];
  logic [2:0]  s_user[N];
  logic        s_valid[N], s_ready[N], s_last[N];
  logic [23:0] m_data[N];
  logic [2:0]  m_user[N];
  logic        m_valid[N], m_ready[N], m_last[N];
  logic [27:0] q[N][$];
  bit          bp[N];
  int          vectors = 0;
  int          miscompares = 0;
  always #5 clk = ~clk;
  function automatic int ratio_of(int i);
    return i == 2 ? 1 : 5;
  endfunction
  function automatic void check(string name, int i, logic [27:0] got, logic [27:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s inst%0d got %h expected %h at %0t", name, i, got, exp, $time);
    end
  endfunction
  for (genvar g = 0; g < N; g++) begin : u
    logic [27:0] prev;
    bit          stalled;
    logic [27:0] cur;
    logic [27:0] e;
    interpolator #(.RATIO(g == 2 ? 1 : 5), .ZERO_STUFF(g == 1)) dut (
      .s_axis_aclk(clk), .s_axis_areset(rst),
      .s_axis_tdata(s_data[g]), .s_axis_tvalid(s_valid[g]), .s_axis_tready(s_ready[g]),
      .s_axis_tuser(s_user[g]), .s_axis_tlast(s_last[g]),
      .m_axis_tdata(m_data[g]), .m_axis_tvalid(m_valid[g]), .m_axis_tready(m_ready[g]),
      .m_axis_tuser(m_user[g]), .m_axis_tlast(m_last[g])
    );
    initial begin
      m_ready[g] = 1'b1;
      forever begin
        @(posedge clk);
        #1 m_ready[g] = bp[g] ? ($urandom_range(2) != 0) : 1'b1;
      end
    end
    initial begin
      stalled = 1'b0;
      forever begin
        @(negedge clk);
        if (rst) begin
          stalled = 1'b0;
        end else begin
          cur = {m_last[g], m_user[g], m_data[g]};
          check("tvalid", g, 28'(m_valid[g]), 28'(q[g].size() != 0));
          check("s_tready", g, 28'(s_ready[g]),
                28'(q[g].size() == 0 || (m_ready[g] && q[g].size() == 1)));
          if (stalled) check("stable", g, {m_valid[g] ? cur : ~prev}, prev);
          if (m_valid[g] && m_ready[g]) begin
            e = q[g].size() != 0 ? q[g].pop_front() : ~cur;
            check("beat", g, cur, e);
          end
          stalled = m_valid[g] && !m_ready[g];
          prev = cur;
        end
      end
    end
  end
  task automatic send(int i, logic [23:0] d, logic [2:0] usr, logic l);
    bit ok = 1'b0;
    s_data[i] = d;
    s_user[i] = usr;
    s_last[i] = l;
    s_valid[i] = 1'b1;
    for (int t = 0; t < 200 && !ok; t++) begin
      @(negedge clk);
      ok = s_ready[i];
    end
    if (!ok) check("accept_timeout", i, 28'd0, 28'd1);
    @(posedge clk);
    if (ok)
      for (int r = 0; r < ratio_of(i); r++)
        q[i].push_back({l && r == ratio_of(i) - 1, usr, (i == 1 && r != 0) ? 24'd0 : d});
    #1 s_valid[i] = 1'b0;
  endtask
  task automatic idle(int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drain();
    int t = 0;
    while ((q[0].size() + q[1].size() + q[2].size()) != 0 && t < 1000) begin
      idle(1);
      t++;
    end
    if (t == 1000) check("drain_timeout", 0, 28'd0, 28'd1);
  endtask
  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < N; i++) s_valid[i] = 1'b0;
    @(posedge clk);
    for (int i = 0; i < N; i++) q[i].delete();
    #1 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check("rst_out", i, {m_valid[i], m_last[i], m_user[i], m_data[i]} , 28'd0);
      check("rst_s_tready", i, 28'(s_ready[i]), 28'd1);
    end
    @(posedge clk);
    #1;
  endtask
  task automatic random_run(int i, int n);
    for (int k = 0; k < n; k++) begin
      idle($urandom_range(0, 3) == 0 ? $urandom_range(1, 6) : 0);
      send(i, 24'($urandom), 3'($urandom), 1'($urandom));
    end
  endtask
  initial begin
    for (int i = 0; i < N; i++) begin
      s_valid[i] = 1'b0;
      s_data[i] = '0;
      s_user[i] = '0;
      s_last[i] = 1'b0;
      bp[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    do_reset();
    send(0, 24'd100, 3'd2, 1'b0);
    send(0, 24'd200, 3'd2, 1'b0);
    drain();
    send(1, -24'sd7, 3'd1, 1'b0);
    send(1, 24'd3, 3'd1, 1'b1);
    drain();
    send(0, 24'h00A0A0, 3'd4, 1'b0);
    send(0, 24'h00B0B0, 3'd4, 1'b1);
    drain();
    bp[0] = 1'b1;
    bp[1] = 1'b1;
    fork
      random_run(0, 40);
      random_run(1, 40);
    join
    drain();
    bp[0] = 1'b0;
    bp[1] = 1'b0;
    send(0, 24'h7FFFFF, 3'd5, 1'b1);
    idle(1);
    do_reset();
    send(0, 24'd5, 3'd0, 1'b0);
    drain();
    bp[2] = 1'b1;
    for (int k = 0; k < 64; k++) send(2, 24'(k), 3'(k), 1'($urandom));
    drain();
    bp[2] = 1'b0;
    fork
      random_run(0, 10);
      random_run(1, 10);
      random_run(2, 20);
    join
    drain();
    idle(2);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
